// File: rtl/peripheral_uart_master_wb.sv
// Wishbone initiator for the 8-bit UART register slave: one classic cycle per command.
// Optional timeout/error path is built when PERIPHERAL_UART_MASTER_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | ready for a command, Wishbone bus idle
// BUS   | cyc/stb asserted, waiting for ack (or timeout)
// RESP  | response held until rsp_ready_i
// GAP   | stb held low so the slave can recover before the next command
module peripheral_uart_master_wb #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int IDLE_GAP       = 3
) (
  input  logic       clk,
  input  logic       wb_rst_ni,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_we_i,
  input  logic [2:0] cmd_adr_i,
  input  logic [7:0] cmd_dat_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_dat_o,
  output logic       rsp_err_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [3:0] wb_sel_o,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i,
  output logic       busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP, S_GAP} state_e;

  localparam logic [3:0] GAP_LOAD = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

  // Named marker in the hierarchy when the timeout is configured below its usable minimum.
  if (TIMEOUT_CYCLES < 4) begin : g_timeout_cycles_below_min
  end

  state_e     state_q, state_d;
  logic       bus_q, bus_d;
  logic       we_q, we_d;
  logic [2:0] adr_q, adr_d;
  logic [7:0] dat_q, dat_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_dat_q, rsp_dat_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic       tmo_hit;

`ifdef PERIPHERAL_UART_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             rsp_err_q, rsp_err_d;

  assign tmo_hit = (tmo_cnt_q == TMO_LAST);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    rsp_err_d = rsp_err_q;
    if (state_q == S_IDLE && cmd_valid_i) begin
      tmo_cnt_d = '0;
    end else if (state_q == S_BUS) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      // ack has priority over a coincident timeout
      if (wb_ack_i) begin
        rsp_err_d = 1'b0;
      end else if (tmo_hit) begin
        rsp_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!wb_rst_ni) begin
      tmo_cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err_o = rsp_err_q;
`else
  assign tmo_hit   = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    bus_d       = bus_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    gap_cnt_d   = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          bus_d   = 1'b1;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (wb_ack_i) begin
          bus_d       = 1'b0;
          rsp_dat_d   = we_q ? 8'h00 : wb_dat_i;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (tmo_hit) begin
          bus_d       = 1'b0;
          rsp_dat_d   = 8'h00;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          if (IDLE_GAP > 0) begin
            gap_cnt_d = GAP_LOAD;
            state_d   = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!wb_rst_ni) begin
      state_q     <= S_IDLE;
      bus_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 3'd0;
      dat_q       <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 8'h00;
      gap_cnt_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      bus_q       <= bus_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  // Gated by reset so no command is offered while the block is held in reset.
  assign cmd_ready_o = (state_q == S_IDLE) && wb_rst_ni;
  assign busy_o      = (state_q != S_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign wb_cyc_o    = bus_q;
  assign wb_stb_o    = bus_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = 4'b0001;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;

endmodule

// File: tb/tb_peripheral_uart_master_wb.sv
// Directed bench for peripheral_uart_master_wb with a 2-cycle-latency register slave model.
// Timeout expectations follow PERIPHERAL_UART_MASTER_TIMEOUT_EN.
module tb_peripheral_uart_master_wb;

  logic       clk = 1'b0;
  logic       wb_rst_ni;
  logic       cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [2:0] cmd_adr_i;
  logic [7:0] cmd_dat_i;
  logic       rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [7:0] rsp_dat_o;
  logic       wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0] wb_sel_o;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o, wb_dat_i;
  logic       wb_ack_i, busy_o;

  logic       slave_on, stray_ack, slv_stage;
  logic [7:0] slave_rdata;
  int         err_cnt = 0;
  int         chk_cnt = 0;
  int         n, g, bad;

  peripheral_uart_master_wb #(.TIMEOUT_CYCLES(16), .IDLE_GAP(3)) dut (
    .clk(clk), .wb_rst_ni(wb_rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Slave registers stb, then acks in the following cycle.
  always @(posedge clk) begin
    if (!wb_rst_ni) slv_stage <= 1'b0;
    else            slv_stage <= wb_stb_o && !slv_stage && slave_on;
  end
  assign wb_ack_i = (slv_stage && wb_stb_o) || stray_ack;
  assign wb_dat_i = slave_rdata;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] adr, input logic [7:0] dat);
    check("issue_ready", cmd_ready_o, 1);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_stb_low(output int cnt, input int limit);
    cnt = 0;
    while (wb_stb_o && cnt < limit) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic consume();
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    check("consume_valid_low", rsp_valid_o, 0);
  endtask

  task automatic wait_ready(input int limit);
    int k = 0;
    while (!cmd_ready_o && k < limit) begin
      k++;
      @(negedge clk);
    end
    check("idle_reached", cmd_ready_o, 1);
  endtask

  initial begin
    wb_rst_ni   = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = 3'd0;
    cmd_dat_i   = 8'h00;
    rsp_ready_i = 1'b0;
    slave_on    = 1'b1;
    stray_ack   = 1'b0;
    slave_rdata = 8'hEE;
    repeat (3) @(negedge clk);

    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_we", wb_we_o, 0);
    check("rst_sel", wb_sel_o, 4'b0001);
    check("rst_adr", wb_adr_o, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_dat", rsp_dat_o, 0);
    check("rst_rsp_err", rsp_err_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_cmd_ready", cmd_ready_o, 0);
    wb_rst_ni = 1'b1;
    @(negedge clk);
    check("post_rst_ready", cmd_ready_o, 1);

    // write 0x83 to register 3
    issue(1'b1, 3'd3, 8'h83);
    check("wr_cyc", wb_cyc_o, 1);
    check("wr_stb", wb_stb_o, 1);
    check("wr_we", wb_we_o, 1);
    check("wr_adr", wb_adr_o, 3);
    check("wr_dat", wb_dat_o, 8'h83);
    check("wr_busy", busy_o, 1);
    check("wr_cmd_ready", cmd_ready_o, 0);
    check("wr_rsp_early", rsp_valid_o, 0);
    wait_stb_low(n, 50);
    check("wr_stb_len", n, 2);
    check("wr_cyc_low", wb_cyc_o, 0);
    check("wr_rsp_valid", rsp_valid_o, 1);
    check("wr_rsp_dat", rsp_dat_o, 8'h00);
    check("wr_rsp_err", rsp_err_o, 0);
    consume();
    check("wr_gap_busy", busy_o, 1);
    wait_ready(50);

    // read register 5 returning 0x60
    slave_rdata = 8'h60;
    issue(1'b0, 3'd5, 8'h00);
    check("rd_we", wb_we_o, 0);
    check("rd_adr", wb_adr_o, 5);
    wait_stb_low(n, 50);
    check("rd_stb_len", n, 2);
    check("rd_rsp_valid", rsp_valid_o, 1);
    check("rd_rsp_dat", rsp_dat_o, 8'h60);
    check("rd_rsp_err", rsp_err_o, 0);
    consume();
    wait_ready(50);

    // back-pressure: response 0xA5 held for 10 cycles
    slave_rdata = 8'hA5;
    issue(1'b0, 3'd1, 8'h00);
    wait_stb_low(n, 50);
    bad = 0;
    repeat (10) begin
      if (rsp_valid_o !== 1'b1 || rsp_dat_o !== 8'hA5 || cmd_ready_o !== 1'b0) bad++;
      @(negedge clk);
    end
    check("bp_stable_bad_cycles", bad, 0);
    check("bp_rsp_dat", rsp_dat_o, 8'hA5);
    consume();
    wait_ready(50);

    // back-to-back reads with cmd_valid held high
    slave_rdata = 8'h11;
    rsp_ready_i = 1'b1;
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = 3'd2;
    @(negedge clk);
    cmd_adr_i = 3'd6;
    check("b2b_adr1", wb_adr_o, 2);
    wait_stb_low(n, 50);
    check("b2b_rsp1_valid", rsp_valid_o, 1);
    check("b2b_rsp1_dat", rsp_dat_o, 8'h11);
    slave_rdata = 8'h22;
    @(negedge clk);
    g = 0;
    while (busy_o && !wb_stb_o && g < 20) begin
      g++;
      @(negedge clk);
    end
    check("b2b_gap_cycles", g, 3);
    check("b2b_idle_stb", wb_stb_o, 0);
    check("b2b_idle_ready", cmd_ready_o, 1);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    check("b2b_stb2", wb_stb_o, 1);
    check("b2b_adr2", wb_adr_o, 6);
    wait_stb_low(n, 50);
    check("b2b_rsp2_dat", rsp_dat_o, 8'h22);
    wait_ready(50);
    rsp_ready_i = 1'b0;

    // slave never acks
    slave_on    = 1'b0;
    slave_rdata = 8'h5A;
    issue(1'b0, 3'd4, 8'h00);
`ifdef PERIPHERAL_UART_MASTER_TIMEOUT_EN
    wait_stb_low(n, 100);
    check("tmo_stb_len", n, 16);
    check("tmo_rsp_valid", rsp_valid_o, 1);
    check("tmo_rsp_err", rsp_err_o, 1);
    check("tmo_rsp_dat", rsp_dat_o, 8'h00);
    consume();
    wait_ready(50);
    issue(1'b0, 3'd4, 8'h00);
    repeat (3) @(negedge clk);
`else
    wait_stb_low(n, 120);
    check("hang_stb_len", n, 120);
    check("hang_rsp_valid", rsp_valid_o, 0);
`endif

    // reset while the bus cycle is active
    check("pre_rst_stb", wb_stb_o, 1);
    wb_rst_ni = 1'b0;
    @(negedge clk);
    check("midrst_stb", wb_stb_o, 0);
    check("midrst_cyc", wb_cyc_o, 0);
    check("midrst_rsp_valid", rsp_valid_o, 0);
    check("midrst_cmd_ready", cmd_ready_o, 0);
    wb_rst_ni = 1'b1;
    @(negedge clk);
    check("after_rst_ready", cmd_ready_o, 1);
    check("after_rst_busy", busy_o, 0);
    check("after_rst_rsp_valid", rsp_valid_o, 0);

    // stray ack while idle
    slave_on  = 1'b1;
    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    stray_ack = 1'b0;
    check("stray_busy", busy_o, 0);
    check("stray_stb", wb_stb_o, 0);
    check("stray_rsp_valid", rsp_valid_o, 0);
    check("stray_rsp_dat", rsp_dat_o, 8'h00);
    @(negedge clk);
    check("stray_ready", cmd_ready_o, 1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
